pdp8_mem_resp: RTL
==================

# pdp8_mem_resp

PDP-8 main-memory responder: the far end of the execute unit's read/write request interface, also serving the decoder's instruction-fetch reads. It holds a 4096 x 12-bit word store and clears it word by word after reset. It answers exec reads with one-cycle registered latency and performs exec writes on any cycle the write request is high. It sits between instr_exec / instr_decode and the rest of the PDP-8 ISA simulator.

## Interface
- MEM_DEPTH, default 4096: number of 12-bit words; must equal 2**`ADDR_WIDTH.
- CLR_VALUE, default 12'o0000: value written to every word during the clear phase.
- clk  in  1  free-running clock.
- reset_n  in  1  reset, asynchronous, active-low.
- ifu_rd_req  in  1  fetch read request (from instr_decode).
- ifu_rd_addr  in  `ADDR_WIDTH  fetch address.
- ifu_rd_data  out  `DATA_WIDTH  fetch read data.
- exec_rd_req  in  1  exec read request.
- exec_rd_addr  in  `ADDR_WIDTH  exec read address.
- exec_rd_data  out  `DATA_WIDTH  exec read data.
- exec_wr_req  in  1  exec write request.
- exec_wr_addr  in  `ADDR_WIDTH  exec write address.
- exec_wr_data  in  `DATA_WIDTH  exec write data.
- mem_ready  out  1  high once the clear phase is complete.
- req_err  out  1  sticky flag: a request arrived while mem_ready was low.
- rd_cnt, wr_cnt  out  16 each  access counters (only with MEM_CNT_EN).

## Operation
- FSM states are CLEAR and READY; reset forces CLEAR.
- CLEAR:
  - 12-bit clr_ptr starts at 0; each cycle writes CLR_VALUE to mem[clr_ptr] and increments clr_ptr.
  - On the cycle clr_ptr==MEM_DEPTH-1 is written, the next state is READY.
  - All requests are ignored (no read update, no write). Any request bit high sets req_err.
- READY:
  - exec_rd_req=1 at edge N: exec_rd_data = mem[exec_rd_addr] from edge N.
  - ifu_rd_req=1 at edge N: ifu_rd_data = mem[ifu_rd_addr] from edge N.
  - The two read ports are independent; both may be active in the same cycle.
  - Read data holds its last value when the request is low.
  - exec_wr_req=1 at edge N: mem[exec_wr_addr] = exec_wr_data at edge N. A request held high for several cycles rewrites the same word; this is idempotent.
- Read and write to the same address in the same cycle: the read returns the OLD data (read-before-write), on both ports.
- Addresses are exactly `ADDR_WIDTH bits; no wrap logic is needed and no out-of-range case exists.
- Once in READY, the block stays there until reset.

## Timing
- Reset values:
  - ifu_rd_data=0, exec_rd_data=0, mem_ready=0, req_err=0, clr_ptr=0; counters 0.
  - The memory array itself is not reset; its contents are defined by the clear phase.
- mem_ready rises 4096 cycles after reset deassertion and is registered.
- Read latency is 1 cycle, which matches exec sampling data in the state after its request.
- Write latency: the write takes effect at the request edge and is visible to a read issued on the next cycle.
- Reset mid-clear or mid-access: immediate return to CLEAR with clr_ptr=0. Any in-flight write at the reset edge is dropped.

## Configuration
- MEM_CNT_EN defined:
  - Adds rd_cnt and wr_cnt ports.
  - rd_cnt increments per READY cycle with exec_rd_req or ifu_rd_req high; a cycle with both high counts +2.
  - wr_cnt increments per READY cycle with exec_wr_req high.
  - Both saturate at 16'hFFFF and clear on reset.
- MEM_CNT_EN undefined: the ports and counter logic are absent; all other behaviour is identical.

## Structure
- pdp8_pkg holds:
  - `ADDR_WIDTH / `DATA_WIDTH (existing).
  - New localparam PDP_MEM_DEPTH=4096.
  - New enum type mem_state_e {MEM_CLEAR, MEM_READY}.
- Sub-module pdp8_mem_array: 1-write / 2-read registered storage, read-before-write, no reset.
- pdp8_mem_resp holds the FSM, clr_ptr, the write mux (clear vs exec), req_err, and the optional counters.

## Test plan
- Reset then idle: mem_ready=0 for cycles 1..4096, 1 at cycle 4097; reading 12'o0000 and 12'o7777 returns 0.
- exec_wr addr 12'o0200 data 12'o1234, next cycle exec_rd 12'o0200 -> exec_rd_data=12'o1234 one cycle later.
- Same cycle: exec_wr 12'o0300=12'o5555 and ifu_rd 12'o0300 (old 0) -> ifu_rd_data=0; read next cycle -> 12'o5555.
- ISZ-style sequence: exec_rd 12'o0050 (=12'o7777), then exec_wr 12'o0050=12'o0000 held 3 cycles -> single final value 0; wr_cnt=3 with MEM_CNT_EN.
- exec_rd_req during CLEAR -> req_err=1 and stays 1, exec_rd_data stays 0; reset clears req_err.
- Assert reset_n=0 at clear cycle 1000 -> mem_ready stays 0 for another full 4096 cycles after release.

Source files
------------

// File: rtl/pdp8_pkg.sv
// Shared PDP-8 definitions: word/address widths, memory depth and
// the memory responder state type.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

package pdp8_pkg;

  localparam int PDP_MEM_DEPTH = 4096;

  typedef enum logic {
    MEM_CLEAR,
    MEM_READY
  } mem_state_e;

endpackage

// File: rtl/pdp8_mem_array.sv
// Word store: one write port, two combinational read ports, no reset.
// Ports: we/waddr/wdata write at clk; ra_a/rd_a and ra_b/rd_b read.
// Reads see the pre-edge contents, so a registered consumer gets
// read-before-write behaviour on a same-address collision.
module pdp8_mem_array
  import pdp8_pkg::*;
#(
  parameter int DEPTH = PDP_MEM_DEPTH
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [`ADDR_WIDTH-1:0] waddr,
  input  logic [`DATA_WIDTH-1:0] wdata,
  input  logic [`ADDR_WIDTH-1:0] ra_a,
  output logic [`DATA_WIDTH-1:0] rd_a,
  input  logic [`ADDR_WIDTH-1:0] ra_b,
  output logic [`DATA_WIDTH-1:0] rd_b
);

  logic [`DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rd_a = mem_q[ra_a];
  assign rd_b = mem_q[ra_b];

endmodule

// File: rtl/pdp8_mem_resp.sv
// PDP-8 main-memory responder: clears the store after reset, then serves
// exec reads/writes and fetch reads with registered 1-cycle read data.
// Ports: clk, reset_n (async low); ifu_rd_*, exec_rd_*, exec_wr_*;
// mem_ready, req_err (sticky); rd_cnt/wr_cnt when MEM_CNT_EN is defined.
module pdp8_mem_resp
  import pdp8_pkg::*;
#(
  parameter int                     MEM_DEPTH = PDP_MEM_DEPTH,
  parameter logic [`DATA_WIDTH-1:0] CLR_VALUE = '0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   ifu_rd_req,
  input  logic [`ADDR_WIDTH-1:0] ifu_rd_addr,
  output logic [`DATA_WIDTH-1:0] ifu_rd_data,
  input  logic                   exec_rd_req,
  input  logic [`ADDR_WIDTH-1:0] exec_rd_addr,
  output logic [`DATA_WIDTH-1:0] exec_rd_data,
  input  logic                   exec_wr_req,
  input  logic [`ADDR_WIDTH-1:0] exec_wr_addr,
  input  logic [`DATA_WIDTH-1:0] exec_wr_data,
  output logic                   mem_ready,
  output logic                   req_err
`ifdef MEM_CNT_EN
  ,
  output logic [15:0]            rd_cnt,
  output logic [15:0]            wr_cnt
`endif
);

  localparam int AW = `ADDR_WIDTH;
  localparam int DW = `DATA_WIDTH;
  localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_DEPTH - 1);

  mem_state_e    state_q, state_d;
  logic [AW-1:0] clr_ptr_q, clr_ptr_d;
  logic          mem_ready_q, mem_ready_d;
  logic          req_err_q, req_err_d;
  logic [DW-1:0] exec_rd_data_q, exec_rd_data_d;
  logic [DW-1:0] ifu_rd_data_q, ifu_rd_data_d;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] exec_word;
  logic [DW-1:0] ifu_word;
  logic          in_clear;
  logic          any_req;

  assign in_clear = (state_q == MEM_CLEAR);
  assign any_req  = ifu_rd_req | exec_rd_req | exec_wr_req;

  // Clear sweep owns the write port until READY; reset drops any write.
  always_comb begin
    mem_we    = reset_n & (in_clear | exec_wr_req);
    mem_waddr = in_clear ? clr_ptr_q : exec_wr_addr;
    mem_wdata = in_clear ? CLR_VALUE : exec_wr_data;
  end

  pdp8_mem_array #(
    .DEPTH (MEM_DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .ra_a  (exec_rd_addr),
    .rd_a  (exec_word),
    .ra_b  (ifu_rd_addr),
    .rd_b  (ifu_word)
  );

  always_comb begin
    state_d        = state_q;
    clr_ptr_d      = clr_ptr_q;
    mem_ready_d    = mem_ready_q;
    req_err_d      = req_err_q;
    exec_rd_data_d = exec_rd_data_q;
    ifu_rd_data_d  = ifu_rd_data_q;
    if (in_clear) begin
      clr_ptr_d = clr_ptr_q + AW'(1);
      if (any_req) req_err_d = 1'b1;
      if (clr_ptr_q == LAST_ADDR) begin
        state_d     = MEM_READY;
        mem_ready_d = 1'b1;
      end
    end else begin
      if (exec_rd_req) exec_rd_data_d = exec_word;
      if (ifu_rd_req)  ifu_rd_data_d  = ifu_word;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= MEM_CLEAR;
      clr_ptr_q      <= '0;
      mem_ready_q    <= 1'b0;
      req_err_q      <= 1'b0;
      exec_rd_data_q <= '0;
      ifu_rd_data_q  <= '0;
    end else begin
      state_q        <= state_d;
      clr_ptr_q      <= clr_ptr_d;
      mem_ready_q    <= mem_ready_d;
      req_err_q      <= req_err_d;
      exec_rd_data_q <= exec_rd_data_d;
      ifu_rd_data_q  <= ifu_rd_data_d;
    end
  end

  assign ifu_rd_data  = ifu_rd_data_q;
  assign exec_rd_data = exec_rd_data_q;
  assign mem_ready    = mem_ready_q;
  assign req_err      = req_err_q;

`ifdef MEM_CNT_EN
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;
  logic [1:0]  rd_inc;
  logic [16:0] rd_sum;

  // Dual read in one cycle counts twice; the carry out saturates.
  always_comb begin
    rd_inc   = {1'b0, exec_rd_req} + {1'b0, ifu_rd_req};
    rd_sum   = {1'b0, rd_cnt_q} + {15'b0, rd_inc};
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (!in_clear) begin
      rd_cnt_d = rd_sum[16] ? 16'hFFFF : rd_sum[15:0];
      if (exec_wr_req && wr_cnt_q != 16'hFFFF)
        wr_cnt_d = wr_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
`endif

endmodule
